// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: walks the PC through a fixed-latency instruction ROM
// and hands each fetched word to decode over a valid/ready handshake.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          ROM_LAT  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        id_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_pc_i,
    output logic        addr_err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Counter preload so that the capture lands exactly ROM_LAT cycles after ISSUE.
    localparam logic [1:0] LAT_M1 = (ROM_LAT > 0) ? 2'(ROM_LAT - 1) : 2'd0;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= 2'd0;
            if_pc_q   <= RESET_PC;
            if_inst_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
        // A redirect outranks everything outside IDLE; in VALID it also retires the held word.
        if (state_q != S_IDLE && redirect_en_i) begin
            pc_d    = redirect_pc_i;
            cnt_d   = 2'd0;
            state_d = (redirect_pc_i[1:0] == 2'b00) ? S_ISSUE : S_ERR;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_ISSUE;
                S_ISSUE: begin
                    if (ROM_LAT == 0) begin
                        if_inst_d = rom_inst_i;
                        if_pc_d   = pc_q;
                        state_d   = S_VALID;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        if_inst_d = rom_inst_i;
                        if_pc_d   = pc_q;
                        state_d   = S_VALID;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                S_VALID: begin
                    if (id_ready_i) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_ISSUE;
                    end
                end
                S_ERR: state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rom_ce_o   = (state_q == S_ISSUE) || (state_q == S_WAIT);
        rom_addr_o = pc_q;
        if_valid_o = (state_q == S_VALID);
        addr_err_o = (state_q == S_ERR);
        if_pc_o    = if_pc_q;
        if_inst_o  = if_inst_q;
    end

endmodule
